// File: rtl/fib_if.sv
// Producer-to-FIFO write port plus control/status lines for fib_gen.
// master drives start/n/full (environment side); slave is the generator.
interface fib_if #(
  parameter int unsigned B   = 8,
  parameter int unsigned N_W = 8
);
  logic           start;
  logic [N_W-1:0] n;
  logic           full;
  logic           wr;
  logic [B-1:0]   w_data;
  logic           busy;
  logic           done;
  logic           ovf;

  modport master (
    output start, n, full,
    input  wr, w_data, busy, done, ovf
  );

  modport slave (
    input  start, n, full,
    output wr, w_data, busy, done, ovf
  );
endinterface

// File: rtl/fib_gen.sv
// Fibonacci producer: emits F(0)..F(n-1) into a FIFO write port, stalling on full
// and tracking which emitted words wrapped mod 2^B.
module fib_gen #(
  parameter int unsigned B   = 8,
  parameter int unsigned N_W = 8
) (
  input logic  clk,
  input logic  reset,
  fib_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StGen, StDone} state_e;

  state_e         state_q, state_d;
  logic [B-1:0]   a_q, a_d;
  logic [B-1:0]   b_q, b_d;
  logic [N_W-1:0] cnt_q, cnt_d;
  logic           a_wrap_q, a_wrap_d;
  logic           b_wrap_q, b_wrap_d;
  logic           ovf_q, ovf_d;

  logic           wr;
  logic [B-1:0]   w_data;
  logic           busy;
  logic           done;
  logic [B:0]     sum;

  assign sum = {1'b0, a_q} + {1'b0, b_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= {{(B-1){1'b0}}, 1'b1};
      cnt_q    <= '0;
      a_wrap_q <= 1'b0;
      b_wrap_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      a_wrap_q <= a_wrap_d;
      b_wrap_q <= b_wrap_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    a_wrap_d = a_wrap_q;
    b_wrap_d = b_wrap_q;
    ovf_d    = ovf_q;
    wr       = 1'b0;
    w_data   = '0;
    done     = 1'b0;
    busy     = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          cnt_d    = bus_io.n;
          a_d      = '0;
          b_d      = {{(B-1){1'b0}}, 1'b1};
          a_wrap_d = 1'b0;
          b_wrap_d = 1'b0;
          ovf_d    = 1'b0;
          state_d  = (bus_io.n != '0) ? StGen : StDone;
        end
      end
      StGen: begin
        // wr is combinational from full so a full FIFO is never written.
        w_data = a_q;
        wr     = ~bus_io.full;
        if (wr) begin
          a_d      = b_q;
          b_d      = sum[B-1:0];
          // A term is "wrapped" if its own add carried or either addend was already wrapped.
          a_wrap_d = b_wrap_q;
          b_wrap_d = sum[B] | a_wrap_q | b_wrap_q;
          ovf_d    = ovf_q | a_wrap_q;
          cnt_d    = cnt_q - 1'b1;
          if (cnt_q == {{(N_W-1){1'b0}}, 1'b1}) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus_io.wr     = wr;
  assign bus_io.w_data = w_data;
  assign bus_io.busy   = busy;
  assign bus_io.done   = done;
  assign bus_io.ovf    = ovf_q;

endmodule

// File: tb/tb_fib_gen.sv
// Scoreboard bench for fib_gen: expected words and ovf are queued at start, checked per write.
module tb_fib_gen;

  typedef struct packed {
    logic [7:0] w;
    logic       o;
  } exp_t;

  logic clk;
  logic reset;
  fib_if #(.B(8), .N_W(8)) bus ();

  fib_gen #(.B(8), .N_W(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: true Fibonacci values, wrap detected against 8 bits.
  task automatic push_exp(input int len);
    longint unsigned fa, fb, t;
    logic sticky;
    exp_t e;
    fa = 0;
    fb = 1;
    sticky = 1'b0;
    for (int k = 0; k < len; k++) begin
      e.w = fa[7:0];
      e.o = sticky;
      q.push_back(e);
      sticky = sticky | (fa > 255);
      t = fa + fb;
      fa = fb;
      fb = t;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.wr) begin
        wr_cnt++;
        check("wr_while_full", bus.full, 0);
        if (q.size() == 0) begin
          check("extra_write", 1, 0);
        end else begin
          check("w_data", bus.w_data, q[0].w);
          check("ovf_at_write", bus.ovf, q[0].o);
          void'(q.pop_front());
        end
      end
      if (bus.done) done_cnt++;
    end
  end

  task automatic run_seq(input string name, input int len, input int st_lo, input int st_hi,
                         input int restart_at, input int exp_cycles);
    int  w0, d0;
    bit  seen;
    push_exp(len);
    w0 = wr_cnt;
    d0 = done_cnt;
    bus.start = 1'b1;
    bus.n     = 8'(len);
    @(posedge clk);
    #1;
    seen = 1'b0;
    for (int i = 1; i <= exp_cycles + 5 && !seen; i++) begin
      bus.full  = (i >= st_lo && i <= st_hi);
      bus.start = (i == restart_at);
      bus.n     = 8'd3;
      @(negedge clk);
      check({name, "_busy"}, bus.busy, 1);
      if (bus.full) begin
        check({name, "_stall_wr"}, bus.wr, 0);
        if (q.size() != 0) check({name, "_stall_wdata"}, bus.w_data, q[0].w);
      end
      if (bus.done) begin
        seen = 1'b1;
        check({name, "_done_cycle"}, i, exp_cycles);
      end
      @(posedge clk);
      #1;
    end
    bus.full  = 1'b0;
    bus.start = 1'b0;
    if (!seen) check({name, "_done_timeout"}, 0, 1);
    check({name, "_writes"}, wr_cnt - w0, len);
    check({name, "_dones"}, done_cnt - d0, 1);
    check({name, "_queue_left"}, q.size(), 0);
    check({name, "_idle_busy"}, bus.busy, 0);
    check({name, "_idle_done"}, bus.done, 0);
  endtask

  initial begin
    int w0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.n     = '0;
    bus.full  = 1'b0;
    @(negedge clk);
    check("rst_wr", bus.wr, 0);
    check("rst_wdata", bus.w_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ovf", bus.ovf, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_seq("t1_n5", 5, 0, -1, -1, 6);
    check("t1_ovf", bus.ovf, 0);
    run_seq("t2_stall", 5, 2, 4, -1, 9);
    run_seq("t3_n0", 0, 0, -1, -1, 1);
    run_seq("t4_n15", 15, 0, -1, -1, 16);
    check("t4_ovf_set", bus.ovf, 1);
    run_seq("t5_restart", 10, 0, -1, 3, 11);
    check("t5_ovf_cleared", bus.ovf, 0);
    run_seq("t5_n2", 2, 0, -1, -1, 3);
    run_seq("t5_stall_wrap", 15, 10, 12, -1, 19);
    check("t5_ovf_set", bus.ovf, 1);

    // Asynchronous reset partway through an 8-term run.
    push_exp(8);
    w0 = wr_cnt;
    bus.start = 1'b1;
    bus.n     = 8'd8;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t6_pre_wr", bus.wr, 1);
    #1;
    reset = 1'b1;
    #1;
    check("t6_async_wr", bus.wr, 0);
    check("t6_async_busy", bus.busy, 0);
    check("t6_async_done", bus.done, 0);
    check("t6_async_ovf", bus.ovf, 0);
    check("t6_writes", wr_cnt - w0, 4);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_no_writes_after", wr_cnt - w0, 4);
    check("t6_idle_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    run_seq("t6_recover", 3, 0, -1, -1, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
